// File: rtl/mult_div_arbiter.sv
// Two-requester round-robin front end for a shared multiplier/divider: loads
// operands A then B, starts the op, waits for completion and returns the result.
module mult_div_arbiter #(
   parameter int unsigned WORD_LENGTH = 9,
   parameter int unsigned TIMEOUT     = 1023
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req0,
   input  logic                       req1,
   input  logic                       op0,
   input  logic                       op1,
   input  logic [WORD_LENGTH-1:0]     a0,
   input  logic [WORD_LENGTH-1:0]     b0,
   input  logic [WORD_LENGTH-1:0]     a1,
   input  logic [WORD_LENGTH-1:0]     b1,
   output logic                       done0,
   output logic                       done1,
   output logic                       err,
   output logic [2*WORD_LENGTH-1:0]   result,
   output logic                       busy,
   output logic                       dp_load,
   output logic                       dp_start,
   output logic                       dp_op,
   output logic [WORD_LENGTH-1:0]     dp_data,
   input  logic                       dp_stored,
   input  logic                       dp_ready,
   input  logic [2*WORD_LENGTH-1:0]   dp_result
);

   localparam int unsigned CntWidth = $clog2(TIMEOUT + 1);

   typedef enum logic [3:0] {
      StIdle, StLoadA, StWaitA, StLoadB, StWaitB, StStart, StWaitBusy, StWaitRdy, StDone
   } state_e;

   state_e                 state_q;
   logic [CntWidth-1:0]    cnt_q;
   logic [CntWidth-1:0]    cnt_inc;
   logic                   timed_out;
   logic                   gnt_q;
   logic                   last_q;
   logic                   pick;
   logic                   advance;
   logic [WORD_LENGTH-1:0] b_q;

   // On a tie the requester not served last wins; last_q resets to 1 so 0 wins first.
   assign pick      = (req0 && req1) ? ~last_q : req1;
   assign cnt_inc   = cnt_q + 1'b1;
   assign timed_out = (cnt_inc == CntWidth'(TIMEOUT));

   always_comb begin
      advance = 1'b0;
      unique case (state_q)
         StLoadA, StLoadB: advance = dp_stored;
         StWaitA, StWaitB: advance = ~dp_stored;
         StWaitBusy:       advance = ~dp_ready;
         StWaitRdy:        advance = dp_ready;
         default:          advance = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         gnt_q    <= 1'b0;
         last_q   <= 1'b1;
         b_q      <= '0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         err      <= 1'b0;
         result   <= '0;
         busy     <= 1'b0;
         dp_load  <= 1'b0;
         dp_start <= 1'b0;
         dp_op    <= 1'b0;
         dp_data  <= '0;
      end else begin
         done0    <= 1'b0;
         done1    <= 1'b0;
         dp_start <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req0 || req1) begin
                  gnt_q   <= pick;
                  last_q  <= pick;
                  b_q     <= pick ? b1 : b0;
                  dp_op   <= pick ? op1 : op0;
                  dp_data <= pick ? a1 : a0;
                  dp_load <= 1'b1;
                  busy    <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= StLoadA;
               end
            end
            StStart: begin
               cnt_q   <= '0;
               state_q <= StWaitBusy;
            end
            StDone: begin
               err     <= 1'b0;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               if (advance) begin
                  cnt_q <= '0;
                  unique case (state_q)
                     StLoadA: begin
                        dp_load <= 1'b0;
                        state_q <= StWaitA;
                     end
                     StWaitA: begin
                        dp_load <= 1'b1;
                        dp_data <= b_q;
                        state_q <= StLoadB;
                     end
                     StLoadB: begin
                        dp_load <= 1'b0;
                        state_q <= StWaitB;
                     end
                     StWaitB: begin
                        dp_data  <= '0;
                        dp_start <= 1'b1;
                        state_q  <= StStart;
                     end
                     StWaitBusy: state_q <= StWaitRdy;
                     StWaitRdy: begin
                        result  <= dp_result;
                        dp_op   <= 1'b0;
                        done0   <= ~gnt_q;
                        done1   <= gnt_q;
                        err     <= 1'b0;
                        state_q <= StDone;
                     end
                     default: state_q <= StIdle;
                  endcase
               end else if (timed_out) begin
                  // Abort: keep the old result and drop every datapath control.
                  cnt_q   <= '0;
                  dp_load <= 1'b0;
                  dp_op   <= 1'b0;
                  dp_data <= '0;
                  done0   <= ~gnt_q;
                  done1   <= gnt_q;
                  err     <= 1'b1;
                  state_q <= StDone;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/mult_div_arbiter.md
MULT_DIV_ARBITER -- requirements
Module: mult_div_arbiter

Interface
REQ-001 Parameter: WORD_LENGTH, default 9, operand width of the shared multiplier/divider.
REQ-002 Parameter: TIMEOUT, default 1023, maximum cycles to wait on any datapath handshake.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req0, req1  input  1 each  requester N wants an operation; held high until its done pulse.
REQ-006 op0, op1  input  1 each  requester N operation select, passed to the datapath op.
REQ-007 a0, b0, a1, b1  input  WORD_LENGTH each  requester N operands A (first) and B (second).
REQ-008 done0, done1  output  1 each  one-cycle pulse when requester N's operation completes.
REQ-009 err  output  1  valid with a done pulse; 1 = operation aborted by timeout.
REQ-010 result  output  2*WORD_LENGTH  registered datapath result of the last completed operation.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 dp_load, dp_start, dp_op  output  1 each  datapath control.
REQ-013 dp_data  output  WORD_LENGTH  datapath operand bus.
REQ-014 dp_stored, dp_ready  input  1 each  datapath operand-latched and operation-complete status.
REQ-015 dp_result  input  2*WORD_LENGTH  datapath result.

Function
REQ-016 FSM states: IDLE, LOAD_A, WAIT_A, LOAD_B, WAIT_B, START, WAIT_BUSY, WAIT_RDY, DONE.
REQ-017 IDLE: with any req high, grant one requester, register its op/a/b, go to LOAD_A next cycle.
REQ-018 Arbitration: round-robin; on simultaneous req0 and req1, grant the requester not granted last; after reset, requester 0 wins first tie.
REQ-019 Only one request is ever granted between IDLE visits; the other request waits and is not lost.
REQ-020 LOAD_A: dp_load=1, dp_data=registered A; stay until dp_stored=1, then go to WAIT_A.
REQ-021 WAIT_A: dp_load=0; stay until dp_stored=0, then go to LOAD_B.
REQ-022 LOAD_B and WAIT_B: identical to LOAD_A and WAIT_A using registered B; WAIT_B exits to START.
REQ-023 START: dp_start=1 for exactly one cycle, dp_op=registered op; next state WAIT_BUSY.
REQ-024 WAIT_BUSY: wait for dp_ready=0, then go to WAIT_RDY.
REQ-025 WAIT_RDY: wait for dp_ready=1; then capture dp_result into result and go to DONE.
REQ-026 DONE: assert the granted requester's done for one cycle with err=0; return to IDLE.
REQ-027 dp_op holds the registered op from LOAD_A through WAIT_RDY; dp_data is 0 outside LOAD/WAIT states.
REQ-028 Timeout: a cycle counter clears on every state change and counts in LOAD_x, WAIT_x, WAIT_BUSY and WAIT_RDY.
REQ-029 When the counter reaches TIMEOUT, go to DONE with err=1; result is left unchanged; all dp_* controls deassert.
REQ-030 Requester deasserting req before done: operation still completes and the done pulse is still issued.
REQ-031 A request is eligible again in the IDLE cycle after its done pulse.
REQ-032 Result width is exactly 2*WORD_LENGTH; no truncation or extension.

Reset
REQ-033 reset low, at any time including mid-operation: state=IDLE; done0, done1, err, busy, dp_load, dp_start, dp_op = 0; dp_data=0; result=0; timeout counter=0; round-robin pointer set so requester 0 wins the next tie.
REQ-034 An operation interrupted by reset is dropped with no done pulse.

Verification
REQ-035 req0, op0=0, a0=9'd12, b0=9'd7; model stores in 1 cycle, ready after 10 cycles -> load A then B, one start pulse, result=84, done0 single pulse, err=0.
REQ-036 req0 and req1 both high from reset -> service order 0, 1, 0, 1; each done pulse matches its requester; never more than one grant per IDLE visit.
REQ-037 dp_stored stuck low, TIMEOUT=15 -> dp_load high 15 cycles, then done pulse with err=1, result unchanged, return to IDLE.
REQ-038 Hold dp_stored high 3 cycles after each load -> LOAD_B does not begin until dp_stored=0; dp_data shows B only in LOAD_B/WAIT_B.
REQ-039 reset asserted during WAIT_RDY -> all outputs 0 immediately; no done; the next request after release is serviced normally.
REQ-040 dp_ready high at start (idle datapath) -> result is not captured until dp_ready has gone low then high again.
